// File: rtl/regfile_write_sequencer_pkg.sv
// Shared types and constants for the register-file write sequencer.
package regfile_write_sequencer_pkg;

  // Sequencer phases: one idle cycle after reset, the clear walk, then normal operation.
  typedef enum logic [1:0] {
    StWait,
    StClear,
    StRun
  } seq_state_e;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned ZERO_REG   = 0;

endpackage

// File: rtl/regfile_write_sequencer_wr_arbiter.sv
// Run-mode arbiter for the register-file write port: core writeback normally wins,
// but a debug request blocked DBG_MAX_WAIT times in a row is forced through.
module regfile_write_sequencer_wr_arbiter
  import regfile_write_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W        = REG_ADDR_W,
  parameter int unsigned DATA_W        = REG_DATA_W,
  parameter int unsigned DBG_MAX_WAIT  = 4,
  parameter bit          HARDWIRE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run_en,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              grant_we,
  output logic [ADDR_W-1:0] grant_addr,
  output logic [DATA_W-1:0] grant_data,
  output logic              core_stall,
  output logic              dbg_ready
);

  localparam int unsigned WaitW = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [WaitW-1:0] MaxWait = WaitW'(DBG_MAX_WAIT);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             grant_core, grant_dbg;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Grant decision and next value of the starvation counter.
  always_comb begin
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    core_stall = 1'b0;
    dbg_ready  = 1'b0;
    wait_cnt_d = wait_cnt_q;
    if (run_en) begin
      wait_cnt_d = '0;
      if (dbg_valid && (wait_cnt_q == MaxWait)) begin
        // Forced debug turn: the core must hold its writeback for a cycle.
        grant_dbg  = 1'b1;
        dbg_ready  = 1'b1;
        core_stall = core_we;
      end else if (core_we) begin
        grant_core = 1'b1;
        // Below MaxWait here, so the increment cannot overflow the saturation point.
        if (dbg_valid) wait_cnt_d = wait_cnt_q + 1'b1;
      end else if (dbg_valid) begin
        grant_dbg = 1'b1;
        dbg_ready = 1'b1;
      end
    end
  end

  // Winner's address/data; a write to the zero register is accepted but not performed.
  always_comb begin
    sel_addr   = grant_dbg ? dbg_addr : core_addr;
    sel_data   = grant_dbg ? dbg_data : core_data;
    grant_addr = (grant_core || grant_dbg) ? sel_addr : '0;
    grant_data = (grant_core || grant_dbg) ? sel_data : '0;
    grant_we   = (grant_core || grant_dbg) &&
                 !(HARDWIRE_ZERO && (sel_addr == ADDR_W'(ZERO_REG)));
  end

  // Starvation counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Owns the register-file write port: clears every entry after reset, then arbitrates
// between core writeback and the debug write channel.
module regfile_write_sequencer
  import regfile_write_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS      = REG_COUNT,
  parameter int unsigned ADDR_W        = REG_ADDR_W,
  parameter int unsigned DATA_W        = REG_DATA_W,
  parameter int unsigned DBG_MAX_WAIT  = 4,
  parameter bit          HARDWIRE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  output logic              core_stall,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              run_en;

  logic              arb_we;
  logic [ADDR_W-1:0] arb_addr;
  logic [DATA_W-1:0] arb_data;
  logic              arb_stall;
  logic              arb_ready;

  assign run_en = (state_q == StRun);

  // Clear-walk FSM: one settle cycle, NUM_REGS zero writes, then run forever.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StWait;
      clr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StWait: begin
          state_q   <= StClear;
          clr_cnt_q <= '0;
        end
        StClear: begin
          if (clr_cnt_q == LastAddr) begin
            state_q   <= StRun;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: begin
          state_q   <= StWait;
          clr_cnt_q <= '0;
        end
      endcase
    end
  end

  regfile_write_sequencer_wr_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .DBG_MAX_WAIT  (DBG_MAX_WAIT),
    .HARDWIRE_ZERO (HARDWIRE_ZERO)
  ) u_wr_arbiter (
    .clk        (clk),
    .reset_n    (reset_n),
    .run_en     (run_en),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .dbg_valid  (dbg_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .grant_we   (arb_we),
    .grant_addr (arb_addr),
    .grant_data (arb_data),
    .core_stall (arb_stall),
    .dbg_ready  (arb_ready)
  );

  // Port mux: clear walk owns the port until RUN, then the arbiter does.
  always_comb begin
    rf_we      = 1'b0;
    rf_addr    = '0;
    rf_wdata   = '0;
    init_done  = 1'b0;
    core_stall = 1'b1;
    dbg_ready  = 1'b0;
    unique case (state_q)
      StWait: begin
        rf_we = 1'b0;
      end
      StClear: begin
        rf_we   = 1'b1;
        rf_addr = clr_cnt_q;
      end
      StRun: begin
        rf_we      = arb_we;
        rf_addr    = arb_addr;
        rf_wdata   = arb_data;
        init_done  = 1'b1;
        core_stall = arb_stall;
        dbg_ready  = arb_ready;
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Self-checking bench for regfile_write_sequencer with a scoreboard of expected port states.
module tb_regfile_write_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_we = 1'b0;
  logic [4:0]  core_addr = '0;
  logic [31:0] core_data = '0;
  logic        dbg_valid = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data = '0;

  logic        a_stall, a_ready, a_we, a_init;
  logic [4:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_stall, b_ready, b_we, b_init;
  logic [4:0]  b_addr;
  logic [31:0] b_wdata;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        ready;
    logic        init;
  } obs_t;

  typedef struct packed {
    obs_t exp;
    obs_t mask;
  } sb_t;

  sb_t  sb_q[$];
  obs_t obs_a, obs_b;
  int   checks = 0;
  int   failures = 0;

  assign obs_a = {a_we, a_addr, a_wdata, a_stall, a_ready, a_init};
  assign obs_b = {b_we, b_addr, b_wdata, b_stall, b_ready, b_init};

  always #5 clk = ~clk;

  regfile_write_sequencer #(
    .HARDWIRE_ZERO (1'b1)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .core_stall (a_stall),
    .dbg_valid  (dbg_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_ready  (a_ready),
    .rf_we      (a_we),
    .rf_addr    (a_addr),
    .rf_wdata   (a_wdata),
    .init_done  (a_init)
  );

  regfile_write_sequencer #(
    .HARDWIRE_ZERO (1'b0)
  ) u_dut_nz (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .core_stall (b_stall),
    .dbg_valid  (dbg_valid),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .dbg_ready  (b_ready),
    .rf_we      (b_we),
    .rf_addr    (b_addr),
    .rf_wdata   (b_wdata),
    .init_done  (b_init)
  );

  function automatic obs_t mk(logic we, logic [4:0] a, logic [31:0] d, logic s, logic r,
                              logic i);
    mk = {we, a, d, s, r, i};
  endfunction

  // care_ad=0 leaves rf_addr/rf_wdata unchecked (idle cycles, where they are unspecified).
  function automatic sb_t ent(obs_t e, logic care_ad);
    ent.exp  = e;
    ent.mask = care_ad ? '1 : mk(1'b1, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1);
  endfunction

  task automatic set_inputs(logic cwe, logic [4:0] ca, logic [31:0] cd, logic dv,
                            logic [4:0] da, logic [31:0] dd);
    core_we   = cwe;
    core_addr = ca;
    core_data = cd;
    dbg_valid = dv;
    dbg_addr  = da;
    dbg_data  = dd;
  endtask

  task automatic test_reset();
    sb_t e;
    set_inputs(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'hA5A5A5A5);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.push_back(ent(mk(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0), 1'b1));
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL reset_hold: got %h want %h", obs_a, e.exp);
    end
    reset_n = 1'b1;
    #1;
    sb_q.push_back(ent(mk(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0), 1'b1));
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL wait_state: got %h want %h", obs_a, e.exp);
    end
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      sb_q.push_back(ent(mk(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0), 1'b1));
      e = sb_q.pop_front();
      checks++;
      if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
        failures++;
        $display("FAIL clear_walk[%0d]: got %h want %h", i, obs_a, e.exp);
      end
    end
    @(posedge clk);
    #1;
    sb_q.push_back(ent(mk(1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 1'b1), 1'b1));
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL init_first_run: got %h want %h", obs_a, e.exp);
    end
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    sb_q.push_back(ent(mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1), 1'b0));
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL run_idle: got %h want %h", obs_a, e.exp);
    end
  endtask

  task automatic test_core_write();
    sb_t e;
    logic [4:0]  addrs[2] = '{5'd5, 5'd31};
    logic [31:0] datas[2] = '{32'hDEADBEEF, 32'h0F0F0F0F};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_inputs(1'b1, addrs[i], datas[i], 1'b0, 5'd0, 32'd0);
      sb_q.push_back(ent(mk(1'b1, addrs[i], datas[i], 1'b0, 1'b0, 1'b1), 1'b1));
      #1;
      e = sb_q.pop_front();
      checks++;
      if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
        failures++;
        $display("FAIL core_write[%0d]: got %h want %h", i, obs_a, e.exp);
      end
    end
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_hardwire_zero();
    sb_t e;
    @(negedge clk);
    set_inputs(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    sb_q.push_back(ent(mk(1'b0, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b1), 1'b1));
    sb_q.push_back(ent(mk(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b1), 1'b1));
    #1;
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL core_zero_dropped: got %h want %h", obs_a, e.exp);
    end
    e = sb_q.pop_front();
    checks++;
    if ((obs_b & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL core_zero_kept: got %h want %h", obs_b, e.exp);
    end
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    sb_q.push_back(ent(mk(1'b0, 5'd0, 32'h55, 1'b0, 1'b1, 1'b1), 1'b1));
    #1;
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL dbg_zero_dropped: got %h want %h", obs_a, e.exp);
    end
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_dbg_only();
    sb_t e;
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 32'h1);
    sb_q.push_back(ent(mk(1'b1, 5'd31, 32'h1, 1'b0, 1'b1, 1'b1), 1'b1));
    #1;
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL dbg_only: got %h want %h", obs_a, e.exp);
    end
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_starvation();
    sb_t e;
    for (int c = 1; c <= 4; c++)
      sb_q.push_back(ent(mk(1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 1'b1), 1'b1));
    sb_q.push_back(ent(mk(1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1), 1'b1));
    sb_q.push_back(ent(mk(1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 1'b1), 1'b1));
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      // Debug drops its request once the forced transfer on cycle 5 has completed.
      set_inputs(1'b1, 5'd3, 32'h11, (c <= 5), 5'd7, 32'hA5A5A5A5);
      #1;
      e = sb_q.pop_front();
      checks++;
      if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
        failures++;
        $display("FAIL starvation_cycle%0d: got %h want %h", c, obs_a, e.exp);
      end
    end
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset_mid_clear();
    sb_t e;
    set_inputs(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'hA5A5A5A5);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(posedge clk);
      #1;
      sb_q.push_back(ent(mk(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0), 1'b1));
      e = sb_q.pop_front();
      checks++;
      if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
        failures++;
        $display("FAIL preclear[%0d]: got %h want %h", i, obs_a, e.exp);
      end
    end
    // Mid-cycle reset while clr_cnt==10: outputs must drop without waiting for an edge.
    #2;
    reset_n = 1'b0;
    #1;
    sb_q.push_back(ent(mk(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0), 1'b1));
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL async_reset: got %h want %h", obs_a, e.exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    sb_q.push_back(ent(mk(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0), 1'b1));
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL rewait: got %h want %h", obs_a, e.exp);
    end
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      sb_q.push_back(ent(mk(1'b1, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0), 1'b1));
      e = sb_q.pop_front();
      checks++;
      if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
        failures++;
        $display("FAIL reclear[%0d]: got %h want %h", i, obs_a, e.exp);
      end
    end
    @(posedge clk);
    #1;
    sb_q.push_back(ent(mk(1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 1'b1), 1'b1));
    e = sb_q.pop_front();
    checks++;
    if ((obs_a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL reinit_run: got %h want %h", obs_a, e.exp);
    end
    @(negedge clk);
    set_inputs(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_hardwire_zero();
    test_dbg_only();
    test_starvation();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
